bus_responder: RTL and testbench

- Responder end of the CPU memory bus (addr, data_in, rden, wren, data_out). Replaces the bare RAM instance.
- Serves a 240-byte data RAM plus a memory-mapped I/O page:
  - output latch
  - synchronized input port
  - transmit FIFO with valid/ready drain
  - prescaled timer
- Read latency matches the existing synchronous RAM, so the CPU stage/IR timing is unchanged.

---
 rtl/bus_responder_pkg.sv | 15 +
 rtl/bus_responder_sync_fifo.sv | 54 +++++
 rtl/bus_responder.sv | 132 +++++++++++++
 tb/tb_bus_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared constants for the CPU bus responder: I/O page addresses and STATUS bit layout.
package bus_responder_pkg;

  localparam logic [7:0] ADDR_OUTP   = 8'hF0;
  localparam logic [7:0] ADDR_INP    = 8'hF1;
  localparam logic [7:0] ADDR_TXDATA = 8'hF2;
  localparam logic [7:0] ADDR_STATUS = 8'hF3;
  localparam logic [7:0] ADDR_TIMER  = 8'hF4;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_TFLAG = 3;

endpackage

// File: rtl/bus_responder_sync_fifo.sv
// Count-based synchronous FIFO. A push into a full FIFO is accepted only
// when a pop happens on the same edge; otherwise the data is dropped.
module sync_fifo
  import bus_responder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: data RAM plus an I/O page (output latch, synchronized
// input, TX FIFO, prescaled timer). Reads register in one cycle like the old RAM.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int RAM_DEPTH  = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMER_DIV  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       rden,
  input  logic       wren,
  output logic [7:0] data_out,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       timer_flag
);

  localparam logic [8:0] RAM_TOP = 9'(RAM_DEPTH);
  localparam int         PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

  logic [7:0]    ram [RAM_DEPTH];
  logic [7:0]    sync1, sync2;
  logic [7:0]    timer;
  logic [PW-1:0] presc;
  logic          overflow;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic          is_ram, status_wr, timer_wr, tick;
  logic [7:0]    status, rd_mux;

  assign is_ram    = ({1'b0, addr} < RAM_TOP);
  assign status_wr = wren && (addr == ADDR_STATUS);
  assign timer_wr  = wren && (addr == ADDR_TIMER);
  assign fifo_push = wren && (addr == ADDR_TXDATA);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;
  assign tick      = (presc == PRE_MAX);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // STATUS register image.
  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow;
    status[ST_TFLAG] = timer_flag;
  end

  // Read data selection by address; unmapped and write-only locations read 0.
  always_comb begin
    rd_mux = '0;
    if (is_ram) begin
      rd_mux = ram[addr];
    end else begin
      case (addr)
        ADDR_OUTP:   rd_mux = out_port;
        ADDR_INP:    rd_mux = sync2;
        ADDR_STATUS: rd_mux = status;
        ADDR_TIMER:  rd_mux = timer;
        default:     rd_mux = '0;
      endcase
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wren && is_ram) ram[addr] <= data_in;
  end

  // Registered read data; a simultaneous write is forwarded straight through.
  always_ff @(posedge clk) begin
    if (rst)       data_out <= '0;
    else if (rden) data_out <= wren ? data_in : rd_mux;
  end

  // Output latch and two-flop input synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_port <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      if (wren && (addr == ADDR_OUTP)) out_port <= data_in;
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Sticky overflow: set by a dropped push, cleared by STATUS write; set wins.
  always_ff @(posedge clk) begin
    if (rst)                                  overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (status_wr && data_in[ST_OVF])    overflow <= 1'b0;
  end

  // Prescaled timer; a TIMER write overrides the increment, flag set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      presc      <= '0;
      timer_flag <= 1'b0;
    end else begin
      if (timer_wr) begin
        timer <= data_in;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) timer <= timer + 8'd1;
      end
      if (!timer_wr && tick && (timer == 8'hFF)) timer_flag <= 1'b1;
      else if (status_wr && data_in[ST_TFLAG])   timer_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: vector table for the address map,
// hand sequences for FIFO, timer and reset corner cases.
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, data_in, in_port;
  logic       rden, wren, tx_ready;
  logic [7:0] data_out, out_port, tx_data;
  logic       tx_valid, timer_flag;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] rd_q[$];
  logic [7:0] fifo_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       r;
    logic       w;
    logic [7:0] exp;
  } vec_t;

  bus_responder #(.RAM_DEPTH(240), .FIFO_DEPTH(4), .TIMER_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .rden       (rden),
    .wren       (wren),
    .data_out   (data_out),
    .in_port    (in_port),
    .out_port   (out_port),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_flag (timer_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle; read expectations go through the scoreboard queue.
  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic r,
                     input logic w, input logic [7:0] exp, input string nm);
    addr = a; data_in = d; rden = r; wren = w;
    if (r) rd_q.push_back(exp);
    @(posedge clk); #1;
    rden = 1'b0; wren = 1'b0;
    if (r) check(nm, data_out, rd_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Push through TXDATA while tx_ready=0, mirroring capacity in the model.
  task automatic push_tx(input logic [7:0] d);
    if (fifo_q.size() < 4) fifo_q.push_back(d);
    cyc(8'hF2, d, 1'b0, 1'b1, 8'h00, "push");
  endtask

  task automatic drain(input string nm);
    tx_ready = 1'b1;
    while (fifo_q.size() > 0) begin
      check({nm, "_valid"}, {7'd0, tx_valid}, 8'd1);
      check({nm, "_data"}, tx_data, fifo_q.pop_front());
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check({nm, "_empty"}, {7'd0, tx_valid}, 8'd0);
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = '{8'h10, 8'h5A, 1'b0, 1'b1, 8'h00};
    vt[1]  = '{8'h10, 8'h00, 1'b1, 1'b0, 8'h5A};
    vt[2]  = '{8'hF8, 8'h00, 1'b1, 1'b0, 8'h00};
    vt[3]  = '{8'hF8, 8'h77, 1'b0, 1'b1, 8'h00};
    vt[4]  = '{8'hF8, 8'h00, 1'b1, 1'b0, 8'h00};
    vt[5]  = '{8'hF1, 8'h00, 1'b1, 1'b0, 8'hC3};
    vt[6]  = '{8'hF0, 8'h81, 1'b0, 1'b1, 8'h00};
    vt[7]  = '{8'hF0, 8'h00, 1'b1, 1'b0, 8'h81};
    vt[8]  = '{8'hF2, 8'h00, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{8'h20, 8'h3C, 1'b1, 1'b1, 8'h3C};
    vt[10] = '{8'h20, 8'h00, 1'b1, 1'b0, 8'h3C};
    vt[11] = '{8'hF3, 8'h00, 1'b1, 1'b0, 8'h01};
    vt[12] = '{8'hEF, 8'h11, 1'b0, 1'b1, 8'h00};
    vt[13] = '{8'hEF, 8'h00, 1'b1, 1'b0, 8'h11};
    vt[14] = '{8'hF5, 8'h99, 1'b0, 1'b1, 8'h00};
    vt[15] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00};

    rst = 1'b1; addr = '0; data_in = '0; rden = 1'b0; wren = 1'b0;
    in_port = 8'hC3; tx_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_data_out", data_out, 8'h00);
    check("rst_out_port", out_port, 8'h00);
    check("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    check("rst_tflag", {7'd0, timer_flag}, 8'd0);

    // Address map vectors.
    for (int i = 0; i < 16; i++)
      cyc(vt[i].a, vt[i].d, vt[i].r, vt[i].w, vt[i].exp, $sformatf("vec%0d", i));
    check("out_port_latch", out_port, 8'h81);

    // FIFO fill past full, then drain.
    for (int i = 1; i <= 5; i++) push_tx(8'(i));
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h06, "status_full_ovf");
    drain("drain1");
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h05, "status_empty_ovf");
    cyc(8'hF3, 8'h04, 1'b0, 1'b1, 8'h00, "ovf_clear");
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h01, "status_cleared");

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) push_tx(8'h11 + 8'(i));
    tx_ready = 1'b1;
    void'(fifo_q.pop_front());
    fifo_q.push_back(8'h09);
    cyc(8'hF2, 8'h09, 1'b0, 1'b1, 8'h00, "push_pop_full");
    tx_ready = 1'b0;
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h02, "status_full_no_ovf");
    drain("drain2");

    // Timer with TIMER_DIV=2: load 0xFE, wrap to 0x00 four edges later.
    cyc(8'hF4, 8'hFE, 1'b0, 1'b1, 8'h00, "timer_load");
    idle(2);
    cyc(8'hF4, 8'h00, 1'b1, 1'b0, 8'hFF, "timer_ff");
    cyc(8'hF3, 8'h08, 1'b0, 1'b1, 8'h00, "tflag_clear_at_wrap");
    check("tflag_set_wins", {7'd0, timer_flag}, 8'd1);
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h09, "status_tflag");
    cyc(8'hF4, 8'h00, 1'b1, 1'b0, 8'h00, "timer_wrapped");
    cyc(8'hF3, 8'h08, 1'b0, 1'b1, 8'h00, "tflag_clear");
    check("tflag_cleared", {7'd0, timer_flag}, 8'd0);

    // Reset mid-operation with a competing write; RAM must survive.
    cyc(8'h10, 8'h00, 1'b1, 1'b0, 8'h5A, "pre_rst_read");
    push_tx(8'h42);
    check("push_empty_valid", {7'd0, tx_valid}, 8'd1);
    fifo_q.delete();
    rst = 1'b1; addr = 8'hF0; data_in = 8'hFF; wren = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wren = 1'b0;
    check("rst2_out_port", out_port, 8'h00);
    check("rst2_data_out", data_out, 8'h00);
    check("rst2_tx_valid", {7'd0, tx_valid}, 8'd0);
    cyc(8'hF3, 8'h00, 1'b1, 1'b0, 8'h01, "rst2_status");
    cyc(8'h10, 8'h00, 1'b1, 1'b0, 8'h5A, "ram_kept");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
